// File: rtl/uart8_receiver_os16_pkg.sv
// Shared definitions for the 8-bit 16x-oversampled UART receiver.
package uart8_receiver_os16_pkg;

  // Frame geometry: 8 data bits, LSB first, no parity.
  localparam int DATA_BITS_N = 8;

  // Receiver states. This is the existing UART state set plus BREAK_WAIT.
  typedef enum logic [2:0] {
    RESET      = 3'd0,
    IDLE       = 3'd1,
    START_BIT  = 3'd2,
    DATA_BITS  = 3'd3,
    STOP_BIT   = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  // Shift one sampled bit into the MSB. The first bit received ends up in bit 0.
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sr, input logic b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look active
// coming out of reset.
module uart_rx_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart8_receiver_os16.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Produces the received byte with a one-cycle done strobe and a framing-error flag.
module uart8_receiver_os16 #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import uart8_receiver_os16_pkg::*;

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  // Half a bit after the falling edge: the middle of the start bit.
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  // One full bit later: the middle of the next bit.
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(OVERSAMPLE - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_s;

  uart_rx_sync #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (rx_s)
  );

  // Receiver FSM with the sample counter, bit index, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET;
      cnt   <= CNT_ZERO;
      idx   <= 3'd0;
      shreg <= 8'h00;
      out   <= 8'h00;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (!en) begin
      // A dropped enable abandons any frame in progress; out is kept.
      state <= RESET;
      cnt   <= CNT_ZERO;
      idx   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          cnt   <= CNT_ZERO;
          idx   <= 3'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        IDLE: begin
          done <= 1'b0;
          if (rx_s == 1'b0) begin
            cnt   <= CNT_ZERO;
            busy  <= 1'b1;
            state <= START_BIT;
          end else begin
            state <= IDLE;
          end
        end

        START_BIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_HALF) begin
            if (rx_s == 1'b0) begin
              cnt   <= CNT_ZERO;
              idx   <= 3'd0;
              state <= DATA_BITS;
            end else begin
              // Line went back high before mid-start-bit: treat as a glitch.
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            state <= START_BIT;
          end
        end

        DATA_BITS: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_FULL) begin
            shreg <= shift_in_lsb_first(shreg, rx_s);
            cnt   <= CNT_ZERO;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP_BIT;
            end else begin
              state <= DATA_BITS;
            end
          end else begin
            state <= DATA_BITS;
          end
        end

        STOP_BIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_FULL) begin
            out  <= shreg;
            done <= 1'b1;
            err  <= ~rx_s;
            busy <= 1'b0;
            cnt  <= CNT_ZERO;
            if (rx_s == 1'b1) begin
              state <= IDLE;
            end else begin
              // Stop bit low: wait for the line to recover so a break is not
              // mistaken for a new start bit.
              state <= BREAK_WAIT;
            end
          end else begin
            state <= STOP_BIT;
          end
        end

        BREAK_WAIT: begin
          done <= 1'b0;
          if (rx_s == 1'b1) begin
            state <= IDLE;
          end else begin
            state <= BREAK_WAIT;
          end
        end

        default: begin
          state <= RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_receiver_os16.sv
// Directed self-checking bench for uart8_receiver_os16.
`timescale 1ns/1ps
module tb_uart8_receiver_os16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int base;
  logic [7:0] rx_log [64];
  logic [7:0] a5 = 8'hA5;
  logic       exp_busy;
  logic       exp_done;

  uart8_receiver_os16 #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // 100 MHz clock, one clk per 1/16 bit, so a nominal bit is 160 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every done pulse and the byte presented with it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      rx_log[done_cnt % 64] <= out;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on the line with a free-running bit time; the line is
  // left at the stop level when the task returns.
  task automatic send_ns(input logic [7:0] d, input logic stop, input realtime bit_ns);
    in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      in = d[i];
      #(bit_ns);
    end
    in = stop;
    #(bit_ns);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    in    = 1'b1;
    #23;
    check("rst_out",  {24'h0, out}, 32'h00);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err",  {31'h0, err},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 0xA5, cycle-accurate: E0 is the third posedge after the pin falls.
    @(posedge clk);
    #1 in = 1'b0;
    for (int c = 1; c <= 175; c++) begin
      @(posedge clk);
      #1;
      exp_busy = ((c - 3) >= 0) && ((c - 3) <= 151);
      exp_done = ((c - 3) == 152);
      check($sformatf("a5_busy_c%0d", c), {31'h0, busy}, {31'h0, exp_busy});
      check($sformatf("a5_done_c%0d", c), {31'h0, done}, {31'h0, exp_done});
      if (c < 160) begin
        if (c / 16 == 0)      in = 1'b0;
        else if (c / 16 <= 8) in = a5[c / 16 - 1];
        else                  in = 1'b1;
      end else begin
        in = 1'b1;
      end
    end
    check("a5_out",   {24'h0, out}, 32'hA5);
    check("a5_err",   {31'h0, err}, 32'h0);
    check("a5_count", done_cnt, 32'd1);

    // Four-cycle low glitch on an idle line.
    base = done_cnt;
    @(posedge clk);
    #1 in = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) in = 1'b1;
      if (c == 5)  check("glitch_busy_hi", {31'h0, busy}, 32'h1);
      if (c == 12) check("glitch_busy_lo", {31'h0, busy}, 32'h0);
    end
    check("glitch_nodone", done_cnt, base);
    check("glitch_out",    {24'h0, out}, 32'hA5);

    // 0x3C with a low stop bit, line held low afterwards.
    base = done_cnt;
    send_ns(8'h3C, 1'b0, 160.0);
    #400;
    check("brk_done",  done_cnt - base, 32'd1);
    check("brk_out",   {24'h0, out}, 32'h3C);
    check("brk_err",   {31'h0, err}, 32'h1);
    check("brk_busy",  {31'h0, busy}, 32'h0);
    in = 1'b1;
    #200;
    check("brk_nonew", done_cnt - base, 32'd1);
    send_ns(8'h55, 1'b1, 160.0);
    in = 1'b1;
    #100;
    check("brk55_done", done_cnt - base, 32'd2);
    check("brk55_out",  {24'h0, out}, 32'h55);
    check("brk55_err",  {31'h0, err}, 32'h0);

    // Back-to-back frames with the line 3% slow, then 3% fast.
    base = done_cnt;
    send_ns(8'h00, 1'b1, 164.8);
    send_ns(8'hFF, 1'b1, 164.8);
    send_ns(8'h81, 1'b1, 164.8);
    in = 1'b1;
    #300;
    check("slow_count", done_cnt - base, 32'd3);
    check("slow_b0", {24'h0, rx_log[(base + 0) % 64]}, 32'h00);
    check("slow_b1", {24'h0, rx_log[(base + 1) % 64]}, 32'hFF);
    check("slow_b2", {24'h0, rx_log[(base + 2) % 64]}, 32'h81);
    check("slow_err", {31'h0, err}, 32'h0);
    base = done_cnt;
    send_ns(8'h00, 1'b1, 155.2);
    send_ns(8'hFF, 1'b1, 155.2);
    send_ns(8'h81, 1'b1, 155.2);
    in = 1'b1;
    #300;
    check("fast_count", done_cnt - base, 32'd3);
    check("fast_b0", {24'h0, rx_log[(base + 0) % 64]}, 32'h00);
    check("fast_b1", {24'h0, rx_log[(base + 1) % 64]}, 32'hFF);
    check("fast_b2", {24'h0, rx_log[(base + 2) % 64]}, 32'h81);
    check("fast_err", {31'h0, err}, 32'h0);

    // rst_n pulse during data bit 4; remaining bits are ones so nothing restarts.
    base = done_cnt;
    fork
      send_ns(8'hF0, 1'b1, 160.0);
      begin
        #850;
        check("mid_busy_pre", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out",  {24'h0, out}, 32'h00);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_err",  {31'h0, err},  32'h0);
        #23;
        rst_n = 1'b1;
      end
    join
    in = 1'b1;
    #300;
    check("mid_rst_nodone", done_cnt, base);
    send_ns(8'h7E, 1'b1, 160.0);
    in = 1'b1;
    #100;
    check("post_rst_count", done_cnt - base, 32'd1);
    check("post_rst_out",   {24'h0, out}, 32'h7E);

    // en dropped for one cycle during data bit 2.
    base = done_cnt;
    fork
      send_ns(8'hFC, 1'b1, 160.0);
      begin
        #560;
        @(negedge clk);
        check("en_busy_pre", {31'h0, busy}, 32'h1);
        en = 1'b0;
        @(negedge clk);
        check("en_busy_drop", {31'h0, busy}, 32'h0);
        en = 1'b1;
      end
    join
    in = 1'b1;
    #300;
    check("en_nodone", done_cnt, base);
    check("en_out_kept", {24'h0, out}, 32'h7E);
    send_ns(8'hC3, 1'b1, 160.0);
    in = 1'b1;
    #100;
    check("en_c3_count", done_cnt - base, 32'd1);
    check("en_c3_out",   {24'h0, out}, 32'hC3);
    check("en_c3_err",   {31'h0, err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart8_receiver_os16.md
# uart8_receiver_os16

8-bit UART receiver, the downstream counterpart of the 8-bit transmitter. It recovers one frame of 1 start bit, 8 data bits (LSB first) and 1 stop bit, with no parity, from the serial line. It uses 16x oversampling for mid-bit sampling. It presents the byte with a one-cycle `done` strobe and a framing-error flag. It sits between the board RX pin and the consuming logic; its `clk` is the system clock divided down to 16x the baud rate.

## Interface
- `OVERSAMPLE`, default 16: clk cycles per bit. Power of two, at least 8. Only 16 is verified.
- `clk  in  1`: 16x baud clock. All logic is on the rising edge.
- `rst_n  in  1`: one clock; reset is asynchronous and active-low.
- `en  in  1`: synchronous enable. Low forces `RESET` on the next edge.
- `in  in  1`: asynchronous serial RX line. Idle level is high.
- `out  out  8`: last received byte. Valid while `done` is high and held until the next frame completes.
- `busy  out  1`: a frame is being received. High in `START_BIT`, `DATA_BITS` and `STOP_BIT`.
- `done  out  1`: one-cycle pulse when a frame completes, whether good or errored.
- `err  out  1`: framing error (stop bit sampled low). Valid with `done`; held until the next `done`.

## Operation
- `in` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`.
- States and transitions:
  - `RESET`: clear the counter and bit index, and clear `busy`, `done` and `err`. Go to `IDLE` when `en` is high.
  - `IDLE`: `done` is low. On `rx_s==0`, clear the counter and go to `START_BIT`.
  - `START_BIT`: increment the counter. When the counter reaches `OVERSAMPLE/2-1`, check `rx_s`:
    - low: this is a valid start. Clear the counter and the bit index, and go to `DATA_BITS`.
    - high: this is a glitch. Go to `IDLE` with `busy` cleared and no `done`.
  - `DATA_BITS`: increment the counter. When the counter reaches `OVERSAMPLE-1`:
    - Shift `rx_s` into the MSB of the shift register, shifting right so the data is LSB first.
    - Clear the counter and increment the bit index.
    - When the bit index is 7 (so it wraps to 0), go to `STOP_BIT`.
  - `STOP_BIT`: when the counter reaches `OVERSAMPLE-1`:
    - Load `out` from the shift register, set `done` for one cycle, set `err` to `~rx_s`, and clear `busy`.
    - If `rx_s` is high, go to `IDLE`. If it is low, go to `BREAK_WAIT`.
  - `BREAK_WAIT`: hold until `rx_s==1`, then go to `IDLE`. This stops a break or stuck-low line from being taken as a start bit.
  - Undefined encodings go to `RESET`.
- Counter width is log2(`OVERSAMPLE`) bits and wraps naturally. The bit index is 3 bits.
- When `en` goes low mid-frame, the frame is discarded with no `done`. `out` keeps its previous value.

## Timing
- Reset values: `out=8'h00`, `busy=0`, `done=0`, `err=0`, state `RESET`. The synchronizer flops reset to 1.
- Let E0 be the edge at which `IDLE` sees `rx_s==0`. `rx_s` lags the pin by 2 cycles.
- Start-bit check at E8. Data bit k sampled at E(8+16(k+1)), so bit 0 at E24 and bit 7 at E136.
- Stop bit sampled at E152. `done`, `out` and `err` are visible after E152. `done` drops after E153.
- The earliest next start is detected at E153, so back-to-back frames at exactly 10 bits per frame are accepted.
- The design tolerates a baud mismatch of about ±4% (sample drift under half a bit over 9.5 bits).
- Asserting `rst_n` low mid-frame clears everything immediately. No `done` is produced.
- `busy` falls on the same edge that `done` rises.

## Structure
- Shared package/header: state encodings, 3 bits, extending the existing UART state set with `BREAK_WAIT`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a reset value parameter. It is reused later for other async inputs.
- Everything else lives in one module: counter, bit index, shift register and FSM.

## Test plan
- Frame 0xA5 at exact baud → `out=8'hA5`, `err=0`, `done` high for exactly 1 cycle at E153; `busy` high E1–E152.
- Low glitch of 4 cycles on idle line → `busy` rises then falls at E9, no `done`, `out` unchanged.
- Frame 0x3C with stop bit low, line held low 40 cycles → `done`, `err=1`, `out=8'h3C`; no new frame until line returns high, then a following 0x55 received with `err=0`.
- Back-to-back 0x00, 0xFF, 0x81 with 1 stop bit and clk ±3% off nominal → three `done` pulses with exactly those bytes.
- `rst_n` pulsed low during bit 4 of a frame → outputs at reset values; next full frame 0x7E received correctly.
- `en` dropped for 1 cycle during bit 2 → no `done` for that frame; `RESET`→`IDLE` then next 0xC3 received.
